instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader: the counterpart of the control decoder. It accepts one operation descriptor per valid/ready handshake, packs it into a 32-bit MIPS word, and writes successive words into instruction memory through a stallable write port. Testbenches and the boot/program-load path use it to build programs for the single-cycle CPU, covering the same instruction subset the decoder supports.

## Interface
Parameters:
- ADDR_W, 8, word-address width of instruction memory (depth 2^ADDR_W)
- BASE_ADDR, 0, first word address written after `start`

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_op  in  5  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLTU, 6 ADDU, 7 SUBU, 8 SLL, 9 NOR, 10 ADDI, 11 ORI, 12 LW, 13 SW, 14 BEQ, 15 LUI, 16 SLTI, 17 J; 18-31 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- in_last  in  1  marks the final descriptor of the program
- im_busy  in  1  memory cannot take a write this cycle
- im_we  out  1  write strobe
- im_addr  out  ADDR_W  word address
- im_wdata  out  32  encoded instruction
- wr_count  out  ADDR_W+1  words written since `start`
- done  out  1  high in DONE
- err_illegal  out  1  sticky: an illegal in_op was consumed
- err_overflow  out  1  sticky: a write was attempted past the top of memory

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE to RUN on `start`. Entering RUN sets the address counter to BASE_ADDR and clears wr_count, err_illegal and err_overflow.
- The datapath is a single output register (`ov` valid bit plus word, address and last flag). In RUN, in_ready = ~ov | (~im_busy). In IDLE and DONE, in_ready = 0.
- On accept, the descriptor is encoded combinationally and loaded into the output register.
- im_we = ov & ~im_busy. The word and address are held stable while im_busy is high.
- Each completed write increments the address counter and wr_count. If the word carried in_last, the FSM moves to DONE in the same edge.
- Encoding:
  - R-type is {6'h00, rs, rt, rd, shamt, funct}. funct values: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, NOR 27, SLT 2A, SLTU 2B, SLL 00 (all hex).
  - SLL forces rs = 0 and uses in_shamt. All other R-type ops force shamt = 0.
  - I-type is {op, rs, rt, imm}. op values: ADDI 08, SLTI 0A, ORI 0D, LUI 0F, LW 23, SW 2B, BEQ 04.
  - LUI forces rs = 0.
  - J is {6'h02, target}.
  - Unused input fields are ignored.
- Illegal in_op: the descriptor is consumed but not loaded, and err_illegal is set. If it carried in_last, the FSM goes directly to DONE once ov is empty.
- Overflow: a word whose address is 2^ADDR_W-1 is written normally. Any later accept sets err_overflow, drops the word and moves to DONE.
- Extra `start` pulses in RUN are ignored.

## Timing
- Reset values: in_ready 0, im_we 0, im_addr BASE_ADDR, im_wdata 0, wr_count 0, done 0, err_illegal 0, err_overflow 0.
- Reset mid-operation aborts immediately. im_we drops asynchronously, so no partial write occurs.
- Latency: accept at edge N gives im_we high in cycle N+1 if im_busy = 0. Throughput is one word per cycle with no bubble.
- Simultaneous accept and write in the same cycle: the old word is written and the new word is loaded at the same edge.
- im_busy held high fills ov and drops in_ready. Once im_busy falls, in_ready recovers in the same cycle (combinational).
- The DONE transition and the done assertion happen on the edge that writes the last word. `start` in DONE re-enters RUN on the next edge.

## Test plan
- ADD rd=3 rs=1 rt=2, then LW rt=8 rs=29 imm=4 (in_last), BASE_ADDR=0 -> writes 0x00221820 at addr 0 and 0x8FA80004 at addr 1, wr_count=2, done=1.
- SLL rd=4 rt=5 shamt=2 rs=7, LUI rt=1 rs=9 imm=0x1234, J target=0x10 -> 0x00052080, 0x3C011234, 0x08000010 (rs forced to 0).
- Back-to-back stream with im_busy high for 3 cycles mid-stream -> no word lost or duplicated, im_addr/im_wdata held, in_ready low while full, addresses contiguous.
- in_op=20 between two legal ops -> err_illegal=1, wr_count=2, no gap in addresses.
- ADDR_W=2, five descriptors -> four writes to addr 0-3, then err_overflow=1, done=1.
- rstn low for one cycle during RUN with ov=1 -> im_we drops at once, all outputs at reset values; a new `start` restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS instruction encoder and instruction-memory loader: packs one operation
// descriptor per handshake into a 32-bit word and streams it into memory.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    input  logic              im_busy,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_ADDU = 5'd6,  OP_SUBU = 5'd7,
        OP_SLL  = 5'd8,  OP_NOR  = 5'd9,  OP_ADDI = 5'd10, OP_ORI  = 5'd11,
        OP_LW   = 5'd12, OP_SW   = 5'd13, OP_BEQ  = 5'd14, OP_LUI  = 5'd15,
        OP_SLTI = 5'd16, OP_J    = 5'd17
    } op_e;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    state_t              state_q, state_d;
    logic                ov_q, ov_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                pend_q, pend_d;
    logic                eill_q, eill_d;
    logic                eovf_q, eovf_d;

    logic                enc_legal;
    logic [31:0]         enc_word;
    logic                accept, write, start_go, past_top;
    logic                load, ill_hit, ovf_hit;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (in_op)
            OP_ADD:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h20);
            OP_ADDU: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h21);
            OP_SUB:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h22);
            OP_SUBU: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h23);
            OP_AND:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h24);
            OP_OR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h25);
            OP_NOR:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h27);
            OP_SLT:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
            OP_SLTU: enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
            OP_SLL:  enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'h00);
            OP_ADDI: enc_word = i_word(6'h08, in_rs, in_rt, in_imm);
            OP_SLTI: enc_word = i_word(6'h0A, in_rs, in_rt, in_imm);
            OP_ORI:  enc_word = i_word(6'h0D, in_rs, in_rt, in_imm);
            OP_LUI:  enc_word = i_word(6'h0F, 5'd0, in_rt, in_imm);
            OP_LW:   enc_word = i_word(6'h23, in_rs, in_rt, in_imm);
            OP_SW:   enc_word = i_word(6'h2B, in_rs, in_rt, in_imm);
            OP_BEQ:  enc_word = i_word(6'h04, in_rs, in_rt, in_imm);
            OP_J:    enc_word = {6'h02, in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    // The word in ov always belongs at addr_q, so ov holding the top address
    // means memory is already spoken for.
    assign accept   = in_valid & in_ready;
    assign write    = ov_q & ~im_busy;
    assign start_go = start & (state_q != S_RUN);
    assign past_top = full_q | (ov_q & (addr_q == TOP));
    assign load     = accept & enc_legal & ~past_top;
    assign ill_hit  = accept & ~enc_legal;
    assign ovf_hit  = accept & enc_legal & past_top;

    // State register
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (ovf_hit)
                    state_d = S_DONE;
                else if (write && last_q)
                    state_d = S_DONE;
                else if ((pend_q || (ill_hit && in_last)) && (!ov_q || write))
                    state_d = S_DONE;
            end
            S_DONE: if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == S_RUN) & (~ov_q | ~im_busy);
        done     = (state_q == S_DONE);
    end

    // Datapath next-state; start has priority so a new program always begins at BASE.
    always_comb begin
        ov_d   = load | (ov_q & ~write);
        word_d = load ? enc_word : word_q;
        last_d = load ? in_last  : last_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        eill_d = eill_q | ill_hit;
        eovf_d = eovf_q | ovf_hit;
        pend_d = (state_d == S_RUN) & (pend_q | (ill_hit & in_last));
        if (write) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + (ADDR_W+1)'(1);
            if (addr_q == TOP) full_d = 1'b1;
        end
        if (start_go) begin
            addr_d = BASE;
            cnt_d  = '0;
            full_d = 1'b0;
            eill_d = 1'b0;
            eovf_d = 1'b0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ov_q   <= 1'b0;
            word_q <= '0;
            last_q <= 1'b0;
            addr_q <= BASE;
            cnt_q  <= '0;
            full_q <= 1'b0;
            pend_q <= 1'b0;
            eill_q <= 1'b0;
            eovf_q <= 1'b0;
        end else begin
            ov_q   <= ov_d;
            word_q <= word_d;
            last_q <= last_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            pend_q <= pend_d;
            eill_q <= eill_d;
            eovf_q <= eovf_d;
        end
    end

    // im_we comes straight from the async-reset valid bit, so reset kills a write at once.
    assign im_we        = write;
    assign im_addr      = addr_q;
    assign im_wdata     = word_q;
    assign wr_count     = cnt_q;
    assign err_illegal  = eill_q;
    assign err_overflow = eovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed and random descriptor streams checked against
// a behavioural model of the MIPS encoding and the memory write sequence.
module tb_instr_encoder;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
    } desc_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, im_busy = 1'b0;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;

    logic        rdy_a, we_a, done_a, eil_a, eov_a;
    logic [7:0]  addr_a;
    logic [31:0] wd_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, we_b, done_b, eil_b, eov_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [2:0]  cnt_b;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .im_busy(im_busy),
        .im_we(we_a), .im_addr(addr_a), .im_wdata(wd_a), .wr_count(cnt_a), .done(done_a),
        .err_illegal(eil_a), .err_overflow(eov_a));

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .im_busy(im_busy),
        .im_we(we_b), .im_addr(addr_b), .im_wdata(wd_b), .wr_count(cnt_b), .done(done_b),
        .err_illegal(eil_b), .err_overflow(eov_b));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit sel = 1'b0;

    logic        cur_rdy, cur_we, cur_done, cur_eil, cur_eov;
    int          cur_addr, cur_cnt;
    logic [31:0] cur_wd;

    always_comb begin
        cur_rdy  = sel ? rdy_b  : rdy_a;
        cur_we   = sel ? we_b   : we_a;
        cur_done = sel ? done_b : done_a;
        cur_eil  = sel ? eil_b  : eil_a;
        cur_eov  = sel ? eov_b  : eov_a;
        cur_addr = sel ? int'(addr_b) : int'(addr_a);
        cur_cnt  = sel ? int'(cnt_b)  : int'(cnt_a);
        cur_wd   = sel ? wd_b : wd_a;
    end

    desc_t send_q[$];
    wr_t   got_q[$];
    wr_t   exp_q[$];

    // Model of the loader: words written so far, memory top, and sticky status.
    int m_n, m_top;
    bit m_done, m_ill, m_ovf;

    // A write is committed at the rising edge following a cycle with im_we high.
    always @(negedge clk) begin
        if (rstn && cur_we) got_q.push_back('{cur_addr, cur_wd});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t mk(input int op, input int rs, input int rt, input int rd,
                                 input int sh, input int imm, input int tgt, input bit last);
        desc_t d;
        d.op = 5'(op); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.sh = 5'(sh);
        d.imm = 16'(imm); d.tgt = 26'(tgt); d.last = last;
        return d;
    endfunction

    function automatic desc_t rnd_desc(input int op, input bit last);
        return mk(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 65535),
                  $urandom_range(0, 32'h3FFFFFF), last);
    endfunction

    // Encoding rules written out as field arithmetic.
    function automatic logic [31:0] ref_encode(input desc_t d);
        int fn [10] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h2B, 32'h21, 32'h23, 32'h00, 32'h27};
        int opc [7] = '{32'h08, 32'h0D, 32'h23, 32'h2B, 32'h04, 32'h0F, 32'h0A};
        int o = int'(d.op);
        logic [31:0] rs = 32'(d.rs), rt = 32'(d.rt), rd = 32'(d.rd), sh = 32'(d.sh);
        if (o <= 9) begin
            if (o == 8) rs = 0; else sh = 0;
            return rs * 32'h200000 + rt * 32'h10000 + rd * 32'h800 + sh * 32'h40 + 32'(fn[o]);
        end else if (o <= 16) begin
            if (o == 15) rs = 0;
            return 32'(opc[o-10]) * 32'h4000000 + rs * 32'h200000 + rt * 32'h10000 + 32'(d.imm);
        end
        return 32'h08000000 + 32'(d.tgt);
    endfunction

    task automatic ref_accept(input desc_t d);
        if (int'(d.op) > 17) begin
            m_ill = 1'b1;
            if (d.last) m_done = 1'b1;
        end else if (m_n > m_top) begin
            m_ovf  = 1'b1;
            m_done = 1'b1;
        end else begin
            exp_q.push_back('{m_n, ref_encode(d)});
            m_n++;
            if (d.last) m_done = 1'b1;
        end
    endtask

    task automatic drive(input desc_t d);
        in_op = d.op; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd; in_shamt = d.sh;
        in_imm = d.imm; in_target = d.tgt; in_last = d.last;
    endtask

    // Called at posedge+1; leaves the selected DUT in RUN.
    task automatic begin_test(input bit which, input int top);
        sel = which;
        m_n = 0; m_top = top; m_done = 0; m_ill = 0; m_ovf = 0;
        got_q.delete(); exp_q.delete();
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // mode 0: no stall, 1: stall over cycles lo..hi, 2: random stalls.
    task automatic run_stream(input int mode, input int lo, input int hi, output int cycles);
        int   cyc = 0;
        bit   acc;
        logic [31:0] held_wd = '0;
        int   held_addr = 0;
        while (send_q.size() > 0 && !m_done && cyc < 2000) begin
            im_busy = (mode == 1) ? (cyc >= lo && cyc <= hi) :
                      (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            drive(send_q[0]);
            in_valid = 1'b1;
            @(negedge clk);
            if (mode == 1 && cyc == lo) begin
                held_addr = cur_addr;
                held_wd   = cur_wd;
                check("busy_ready_low", cur_rdy, 0);
                check("busy_we_low", cur_we, 0);
            end else if (mode == 1 && cyc > lo && cyc <= hi) begin
                check("busy_ready_low", cur_rdy, 0);
                check("busy_we_low", cur_we, 0);
                check("busy_addr_held", cur_addr, held_addr);
                check("busy_data_held", cur_wd, held_wd);
            end else if (mode == 1 && cyc == hi + 1) begin
                check("busy_ready_recover", cur_rdy, 1);
            end
            acc = cur_rdy;
            @(posedge clk); #1;
            if (acc) ref_accept(send_q.pop_front());
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        im_busy  = 1'b0;
        send_q.delete();
        cycles = cyc;
    endtask

    task automatic settle();
        int n = 0;
        while (!cur_done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_within_bound", cur_done, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
        end
        check({tag, "_wr_count"}, cur_cnt, m_n);
        check({tag, "_done"}, cur_done, m_done);
        check({tag, "_err_illegal"}, cur_eil, m_ill);
        check({tag, "_err_overflow"}, cur_eov, m_ovf);
        check({tag, "_ready_idle"}, cur_rdy, 0);
    endtask

    initial begin
        int cycles;

        // Reset values
        #2;
        check("rst_ready", rdy_a, 0);
        check("rst_we", we_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wd_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_done", done_a, 0);
        check("rst_errs", {eil_a, eov_a}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // ADD then LW(last)
        begin_test(0, 255);
        send_q.push_back(mk(0, 1, 2, 3, 9, 16'hFFFF, 0, 0));
        send_q.push_back(mk(12, 29, 8, 17, 3, 4, 0, 1));
        run_stream(0, 0, 0, cycles);
        check("t1_throughput", cycles, 2);
        settle();
        check("t1_word0", got_q.size() > 0 ? got_q[0].data : 32'hx, 32'h00221820);
        check("t1_word1", got_q.size() > 1 ? got_q[1].data : 32'hx, 32'h8FA80004);
        compare_all("t1");

        // SLL / LUI / J with forced rs
        begin_test(0, 255);
        check("restart_done_low", cur_done, 0);
        send_q.push_back(mk(8, 7, 5, 4, 2, 0, 0, 0));
        send_q.push_back(mk(15, 9, 1, 0, 0, 16'h1234, 0, 0));
        send_q.push_back(mk(17, 0, 0, 0, 0, 0, 26'h10, 1));
        run_stream(0, 0, 0, cycles);
        settle();
        check("t2_sll", got_q.size() > 0 ? got_q[0].data : 32'hx, 32'h00052080);
        check("t2_lui", got_q.size() > 1 ? got_q[1].data : 32'hx, 32'h3C011234);
        check("t2_j", got_q.size() > 2 ? got_q[2].data : 32'hx, 32'h08000010);
        compare_all("t2");

        // Stall window mid-stream
        begin_test(0, 255);
        for (int i = 0; i < 10; i++) send_q.push_back(rnd_desc($urandom_range(0, 17), i == 9));
        run_stream(1, 3, 5, cycles);
        settle();
        compare_all("t3");

        // Illegal op between two legal ops
        begin_test(0, 255);
        send_q.push_back(rnd_desc(0, 0));
        send_q.push_back(rnd_desc(20, 0));
        send_q.push_back(rnd_desc(1, 1));
        run_stream(0, 0, 0, cycles);
        settle();
        compare_all("t4");

        // Illegal op carrying the last flag
        begin_test(0, 255);
        send_q.push_back(rnd_desc(10, 0));
        send_q.push_back(rnd_desc(31, 1));
        run_stream(0, 0, 0, cycles);
        settle();
        compare_all("t5");

        // Random programs with random stalls
        for (int t = 0; t < 3; t++) begin
            begin_test(0, 255);
            for (int i = 0; i < 24; i++) send_q.push_back(rnd_desc($urandom_range(0, 17), i == 23));
            run_stream(2, 0, 0, cycles);
            settle();
            compare_all("t6");
        end

        // Overflow on a four-word memory
        begin_test(1, 3);
        for (int i = 0; i < 5; i++) send_q.push_back(rnd_desc($urandom_range(0, 17), 0));
        run_stream(0, 0, 0, cycles);
        settle();
        compare_all("t7");

        // Reset during RUN with a word pending
        begin_test(0, 255);
        drive(mk(3, 1, 2, 3, 0, 0, 0, 0));
        in_valid = 1'b1;
        im_busy  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        im_busy  = 1'b0;
        #1;
        check("t8_we_before_rst", we_a, 1);
        rstn = 1'b0;
        #1;
        check("t8_we_async_drop", we_a, 0);
        check("t8_ready", rdy_a, 0);
        check("t8_addr", addr_a, 0);
        check("t8_wdata", wd_a, 0);
        check("t8_count", cnt_a, 0);
        check("t8_flags", {done_a, eil_a, eov_a}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        begin_test(0, 255);
        send_q.push_back(rnd_desc(6, 1));
        run_stream(0, 0, 0, cycles);
        settle();
        compare_all("t8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
